// File: rtl/adc_avg_filter_if.sv
// Sample handshake between adc_capture and adc_avg_filter.
// adc_capture drives the master side; the filter is the slave.
interface adc_avg_filter_if;
   logic        adc_ready;
   logic [2:0]  address;
   logic [11:0] d_signal;
   logic        adc_ack;

   modport master (
      output adc_ready,
      output address,
      output d_signal,
      input  adc_ack
   );

   modport slave (
      input  adc_ready,
      input  address,
      input  d_signal,
      output adc_ack
   );
endinterface

// File: rtl/adc_avg_filter.sv
// Boxcar moving average over the last 2^LOG2_DEPTH samples of one ADC channel.
// Optional spike clamp: define ADC_FILT_SPIKE_EN.
module adc_avg_filter #(
   parameter int          LOG2_DEPTH = 3,
   parameter logic [2:0]  CHANNEL    = 3'b001,
   parameter logic [11:0] SPIKE_LIM  = 12'd256
) (
   input  logic             clk,
   input  logic             rst,
   adc_avg_filter_if.slave  adc,
   input  logic             flush,
   output logic [11:0]      filt_data,
   output logic             filt_valid,
   output logic             primed
);

   localparam int SW    = 12 + LOG2_DEPTH;
   localparam int DEPTH = 1 << LOG2_DEPTH;
   localparam logic [LOG2_DEPTH:0] FULL = {1'b1, {LOG2_DEPTH{1'b0}}};

`ifdef ADC_FILT_SPIKE_EN
   localparam bit SPIKE_EN = 1'b1;
`else
   localparam bit SPIKE_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE, ACK, UPDATE, OUTPUT, RELEASE
   } state_t;

   state_t state, state_nxt;

   logic [11:0]           smp, old, clamped;
   logic [11:0]           lo_v, hi_v;
   logic [12:0]           hi_w;
   logic [2:0]            addr;
   logic [11:0]           mem [DEPTH];
   logic [SW-1:0]         sum, sum_nxt;
   logic [LOG2_DEPTH:0]   count, count_nxt;
   logic [LOG2_DEPTH-1:0] wr_ptr;
   logic                  full;

   assign full        = (count == FULL);
   assign adc.adc_ack = (state == ACK);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (adc.adc_ready) state_nxt = ACK;
         ACK:     state_nxt = (addr == CHANNEL) ? UPDATE : RELEASE;
         UPDATE:  state_nxt = OUTPUT;
         OUTPUT:  state_nxt = RELEASE;
         RELEASE: if (!adc.adc_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (flush) state_nxt = RELEASE;
   end

   // Once the window is full the oldest sample leaves as the new one enters
   always_comb begin
      if (full) begin
         sum_nxt   = sum + SW'(smp) - SW'(old);
         count_nxt = count;
      end else begin
         sum_nxt   = sum + SW'(smp);
         count_nxt = count + (LOG2_DEPTH+1)'(1);
      end
   end

   always_comb begin
      hi_w    = {1'b0, filt_data} + {1'b0, SPIKE_LIM};
      hi_v    = hi_w[12] ? 12'hFFF : hi_w[11:0];
      lo_v    = (filt_data > SPIKE_LIM) ? filt_data - SPIKE_LIM : 12'd0;
      clamped = smp;
      if (smp > hi_v) clamped = hi_v;
      if (smp < lo_v) clamped = lo_v;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         smp        <= '0;
         addr       <= '0;
         old        <= '0;
         sum        <= '0;
         count      <= '0;
         wr_ptr     <= '0;
         filt_data  <= '0;
         filt_valid <= 1'b0;
         primed     <= 1'b0;
      end else begin
         filt_valid <= 1'b0;
         if (flush) begin
            sum    <= '0;
            count  <= '0;
            wr_ptr <= '0;
            primed <= 1'b0;
         end else begin
            case (state)
               IDLE: if (adc.adc_ready) begin
                  smp  <= adc.d_signal;
                  addr <= adc.address;
               end
               ACK: begin
                  old <= mem[wr_ptr];
                  if (SPIKE_EN && primed) smp <= clamped;
               end
               UPDATE: begin
                  sum    <= sum_nxt;
                  count  <= count_nxt;
                  wr_ptr <= wr_ptr + LOG2_DEPTH'(1);
                  primed <= (count_nxt == FULL);
                  // Registered here so data and valid line up in OUTPUT
                  if (count_nxt == FULL) begin
                     filt_data  <= sum_nxt[SW-1:LOG2_DEPTH];
                     filt_valid <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state == UPDATE && !flush) mem[wr_ptr] <= smp;
   end

endmodule

// File: tb/tb_adc_avg_filter.sv
// Scoreboard bench for adc_avg_filter against a queue-based window model.
// Honours ADC_FILT_SPIKE_EN in the reference model.
module tb_adc_avg_filter;

   localparam int         L   = 3;
   localparam int         D   = 8;
   localparam logic [2:0] CH  = 3'b001;
   localparam int         LIM = 256;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [11:0] filt_data;
   logic        filt_valid;
   logic        primed;

   adc_avg_filter_if ifc ();

   adc_avg_filter #(
      .LOG2_DEPTH (L),
      .CHANNEL    (CH),
      .SPIKE_LIM  (12'd256)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .adc        (ifc.slave),
      .flush      (flush),
      .filt_data  (filt_data),
      .filt_valid (filt_valid),
      .primed     (primed)
   );

   always #20 clk = ~clk;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   ack_cnt = 0;
   int   ack_cyc = -100;
   logic prev_ack = 1'b0;
   int   win[$];
   int   exp_q[$];
   int   m_mean = 0;
   bit   m_primed = 1'b0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      int e;
      if (rst) begin
         if (prev_ack) chk("ack_width", 32'(ifc.adc_ack), 0);
         if (ifc.adc_ack) begin
            ack_cnt++;
            ack_cyc = cyc;
         end
         prev_ack = ifc.adc_ack;
         if (filt_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_valid", 32'(filt_valid), 0);
            end else begin
               e = exp_q.pop_front();
               chk("filt_data", 32'(filt_data), e);
               chk("latency", cyc - ack_cyc, 2);
               chk("primed_on_valid", 32'(primed), 1);
            end
         end
      end
   end

   task automatic model(input logic [2:0] a, input int d);
      int s;
      int v;
      if (a != CH) return;
      v = d;
`ifdef ADC_FILT_SPIKE_EN
      if (m_primed) begin
         if (v > m_mean + LIM)
            v = (m_mean + LIM > 4095) ? 4095 : m_mean + LIM;
         if (v < m_mean - LIM)
            v = (m_mean - LIM < 0) ? 0 : m_mean - LIM;
      end
`endif
      win.push_back(v);
      if (win.size() > D) void'(win.pop_front());
      if (win.size() == D) begin
         s = 0;
         foreach (win[i]) s += win[i];
         m_mean   = s / D;
         m_primed = 1'b1;
         exp_q.push_back(m_mean);
      end
   endtask

   task automatic send(input logic [2:0] a, input logic [11:0] d,
                       input int hold);
      int a0;
      a0 = ack_cnt;
      @(posedge clk);
      #1;
      ifc.adc_ready = 1'b1;
      ifc.address   = a;
      ifc.d_signal  = d;
      model(a, int'(d));
      repeat (hold) @(posedge clk);
      #1;
      ifc.adc_ready = 1'b0;
      ifc.address   = 3'($urandom);
      ifc.d_signal  = 12'($urandom);
      repeat (6) @(posedge clk);
      chk("ack_count", ack_cnt - a0, 1);
   endtask

   task automatic do_flush();
      @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      win.delete();
      m_primed = 1'b0;
      @(negedge clk);
      chk("primed_flush", 32'(primed), 0);
      chk("flush_keeps_data", 32'(filt_data), m_mean);
   endtask

   initial begin
      logic [2:0]  a;
      logic [11:0] d;
      rst           = 1'b0;
      flush         = 1'b0;
      ifc.adc_ready = 1'b0;
      ifc.address   = '0;
      ifc.d_signal  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ack", 32'(ifc.adc_ack), 0);
      chk("rst_valid", 32'(filt_valid), 0);
      chk("rst_primed", 32'(primed), 0);
      chk("rst_data", 32'(filt_data), 0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_ack", 32'(ifc.adc_ack), 0);
      chk("idle_valid", 32'(filt_valid), 0);

      for (int i = 0; i < 8; i++) begin
         send(CH, 12'd1000, 1);
         if (i == 6) chk("not_primed_7", 32'(primed), 0);
      end
      chk("primed_8", 32'(primed), 1);
      chk("prime_data", 32'(filt_data), 1000);

      for (int i = 0; i < 8; i++) send(CH, 12'd2000, 1 + i % 3);
      chk("slide_end", 32'(filt_data), 2000);

      send(3'b000, 12'd4095, 1);
      chk("drop_data", 32'(filt_data), 2000);
      send(CH, 12'd2000, 1);

      send(CH, 12'd500, 20);

      do_flush();
      for (int i = 0; i < 8; i++) begin
         send(CH, 12'd1000, 1);
         if (i == 6) chk("reprime_wait", 32'(primed), 0);
      end
      chk("reprimed", 32'(primed), 1);

      send(CH, 12'd4000, 1);
`ifdef ADC_FILT_SPIKE_EN
      chk("spike", 32'(filt_data), 1032);
`else
      chk("spike", 32'(filt_data), 1375);
`endif

      do_flush();
      for (int i = 0; i < 60; i++) begin
         a = ($urandom % 4 == 0) ? 3'($urandom) : CH;
         d = 12'($urandom);
         send(a, d, $urandom_range(1, 5));
         if ($urandom % 25 == 0) do_flush();
      end
      chk("queue_drained", exp_q.size(), 0);

      @(posedge clk);
      #1;
      ifc.adc_ready = 1'b1;
      ifc.address   = CH;
      ifc.d_signal  = 12'd777;
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("midrst_ack", 32'(ifc.adc_ack), 0);
      chk("midrst_primed", 32'(primed), 0);
      chk("midrst_data", 32'(filt_data), 0);
      ifc.adc_ready = 1'b0;
      win.delete();
      m_primed = 1'b0;
      m_mean   = 0;
      @(negedge clk);
      prev_ack = 1'b0;
      rst = 1'b1;
      send(CH, 12'd100, 1);
      chk("post_rst_primed", 32'(primed), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
